// File: rtl/instruction_fetch_r.sv
// Fetch stage: walks a byte-wide, big-endian instruction memory one 32-bit
// word per cycle. A start/stall/halt FSM paces the program, and a sentinel
// word or the end of memory stops it.
module instruction_fetch_r #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic        halted
);

  localparam int          AW      = $clog2(MEM_DEPTH);
  localparam logic [31:0] LAST_FP = 32'(MEM_DEPTH - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // Program storage; contents are placed here by whoever owns the program
  // image and are never written by this block.
  logic [7:0] mem [0:MEM_DEPTH-1];

  state_t      state_q, state_d;
  logic [31:0] fp_q, fp_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  logic [AW-1:0] idx;
  logic [31:0]   fetch_word;
  logic          unused_fp_hi;

  // fp never exceeds the memory, so only its low address bits select bytes.
  assign idx          = fp_q[AW-1:0];
  assign unused_fp_hi = ^fp_q[31:AW];

  // Assemble the big-endian word: byte at fp is the most significant.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign fetch_word[31-8*gi -: 8] = mem[idx + AW'(gi)];
    end
  endgenerate

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d  = state_q;
    fp_d     = fp_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        // Stall is ignored here; a start with stall enters RUN frozen.
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (fetch_word == HALT_WORD) begin
            // pc_out keeps pointing at the last real instruction.
            instr_d  = '0;
            valid_d  = 1'b0;
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            instr_d = fetch_word;
            pc_d    = fp_q;
            valid_d = 1'b1;
            if (fp_q == LAST_FP) begin
              // Last word in memory is still issued; no wrap back to 0.
              halted_d = 1'b1;
              state_d  = HALT;
            end else begin
              fp_d = fp_q + 32'd4;
            end
          end
        end
      end
      HALT: begin
        // Drop whatever was issued on the way in; only reset leaves.
        instr_d = '0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fp_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fp_q     <= fp_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_q;
  assign halted      = halted_q;

endmodule
